// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation every three cycles: grant, execute, done.
module alu_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [2:0] oc0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   output logic       ack0,
   input  logic       req1,
   input  logic [2:0] oc1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       ack1,
   output logic [2:0] alu_oc,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_f,
   output logic [3:0] res,
   output logic       res_valid,
   output logic       res_id,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic [2:0] oc_q, oc_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [3:0] res_q, res_d;
   logic       vld_q, vld_d;
   logic       rid_q, rid_d;
   logic       last_q, last_d;

   logic       any_req;
   logic       gnt_id;

   assign any_req = req0 | req1;
   // On a tie the requester not served last wins.
   assign gnt_id  = (req0 & req1) ? ~last_q : req1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack0_d = ack0_q;
      ack1_d = ack1_q;
      oc_d   = oc_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      vld_d  = vld_q;
      rid_d  = rid_q;
      last_d = last_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               ack0_d = ~gnt_id;
               ack1_d = gnt_id;
               last_d = gnt_id;
               oc_d   = gnt_id ? oc1 : oc0;
               a_d    = gnt_id ? a1  : a0;
               b_d    = gnt_id ? b1  : b0;
            end
         end
         EXEC: begin
            ack0_d = 1'b0;
            ack1_d = 1'b0;
            res_d  = alu_f;
            rid_d  = last_q;
            vld_d  = 1'b1;
         end
         DONE: begin
            vld_d  = 1'b0;
         end
         default: begin
            ack0_d = 1'b0;
            ack1_d = 1'b0;
            vld_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         oc_q   <= 3'd0;
         a_q    <= 4'd0;
         b_q    <= 4'd0;
         res_q  <= 4'd0;
         vld_q  <= 1'b0;
         rid_q  <= 1'b0;
         last_q <= 1'b1;
      end else begin
         ack0_q <= ack0_d;
         ack1_q <= ack1_d;
         oc_q   <= oc_d;
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         vld_q  <= vld_d;
         rid_q  <= rid_d;
         last_q <= last_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign alu_oc    = oc_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign res       = res_q;
   assign res_valid = vld_q;
   assign res_id    = rid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic,
// checked against a cycles-since-grant reference model.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] oc0 = '0, oc1 = '0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       ack0, ack1;
   logic [2:0] alu_oc;
   logic [3:0] alu_a, alu_b, alu_f, res;
   logic       res_valid, res_id, busy;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int         t;
   bit         last;
   bit         gid;
   logic [2:0] m_oc;
   logic [3:0] m_a, m_b, m_res;
   bit         m_rid;

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_fn(logic [2:0] op,
                                         logic [3:0] a,
                                         logic [3:0] b);
      logic [7:0] p;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: begin p = a * b; return p[3:0]; end
         3'd3: return (b == 0) ? 4'd0 : a / b;
         3'd4: return ~a;
         3'd5: return a ^ b;
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_f = alu_fn(alu_oc, alu_a, alu_b);

   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .oc0(oc0), .a0(a0), .b0(b0), .ack0(ack0),
      .req1(req1), .oc1(oc1), .a1(a1), .b1(b1), .ack1(ack1),
      .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .res(res), .res_valid(res_valid), .res_id(res_id), .busy(busy)
   );

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t = 3; last = 1'b1; gid = 1'b0;
      m_oc = '0; m_a = '0; m_b = '0; m_res = '0; m_rid = 1'b0;
   endtask

   // Called right after a rising edge with the inputs seen at that edge.
   task automatic model_edge();
      bit w;
      if (t < 3) t++;
      if (t == 1) begin
         m_res = alu_fn(m_oc, m_a, m_b);
         m_rid = gid;
      end
      if (t >= 3 && (req0 || req1)) begin
         w    = (req0 && req1) ? !last : req1;
         gid  = w;
         last = w;
         m_oc = w ? oc1 : oc0;
         m_a  = w ? a1 : a0;
         m_b  = w ? b1 : b0;
         t    = 0;
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".ack0"}, 8'(ack0), 8'(t == 0 && !gid));
      chk({tag, ".ack1"}, 8'(ack1), 8'(t == 0 && gid));
      chk({tag, ".res_valid"}, 8'(res_valid), 8'(t == 1));
      chk({tag, ".busy"}, 8'(busy), 8'(t < 2));
      chk({tag, ".res"}, 8'(res), 8'(m_res));
      chk({tag, ".res_id"}, 8'(res_id), 8'(m_rid));
      chk({tag, ".alu_oc"}, 8'(alu_oc), 8'(m_oc));
      chk({tag, ".alu_a"}, 8'(alu_a), 8'(m_a));
      chk({tag, ".alu_b"}, 8'(alu_b), 8'(m_b));
   endtask

   task automatic step(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Asynchronous reset landing in the middle of a cycle.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("midrst");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      apply_reset();

      // Single ADD from requester 0
      req0 = 1; oc0 = 3'd0; a0 = 4'd7; b0 = 4'd5;
      step("add.g");
      req0 = 0;
      step("add.r");
      chk("add.const", 8'(res), 8'd12);
      step("add.d");
      step("add.i");

      // Tie after reset: grants alternate 0,1,0
      apply_reset();
      req0 = 1; oc0 = 3'd2; a0 = 4'd3; b0 = 4'd4;
      req1 = 1; oc1 = 3'd1; a1 = 4'd2; b1 = 4'd5;
      step("tie.g0");
      step("tie.r0");
      chk("tie.res0", 8'({res_id, res}), 8'({1'b0, 4'd12}));
      step("tie.d0");
      step("tie.g1");
      step("tie.r1");
      chk("tie.res1", 8'({res_id, res}), 8'({1'b1, 4'd13}));
      step("tie.d1");
      step("tie.g2");
      step("tie.r2");
      chk("tie.res2", 8'({res_id, res}), 8'({1'b0, 4'd12}));
      req0 = 0; req1 = 0;
      step("tie.d2");

      // Divide by zero, then a normal divide
      apply_reset();
      req1 = 1; oc1 = 3'd3; a1 = 4'd9; b1 = 4'd0;
      step("div0.g");
      req1 = 0;
      step("div0.r");
      chk("div0.res", 8'({res_id, res}), 8'({1'b1, 4'd0}));
      step("div0.d");
      req1 = 1; b1 = 4'd2;
      step("div.g");
      req1 = 0;
      step("div.r");
      chk("div.res", 8'(res), 8'd4);
      step("div.d");

      // Operands changing after the grant must not matter
      apply_reset();
      req0 = 1; oc0 = 3'd7; a0 = 4'hF; b0 = 4'h3;
      step("and.g");
      req0 = 0; a0 = 4'h0;
      step("and.r");
      chk("and.res", 8'(res), 8'd3);
      step("and.d");

      // Reset during EXEC aborts; held request is re-granted
      apply_reset();
      req0 = 1; oc0 = 3'd0; a0 = 4'd1; b0 = 4'd1;
      step("ab.g");
      mid_reset();
      step("ab.g2");
      step("ab.r");
      chk("ab.res", 8'(res), 8'd2);
      req0 = 0;
      step("ab.d");

      // Request 1 pulses only while busy and is dropped
      apply_reset();
      req0 = 1; oc0 = 3'd5; a0 = 4'hA; b0 = 4'h5;
      step("drop.g");
      req0 = 0; req1 = 1; oc1 = 3'd6;
      step("drop.e");
      req1 = 0;
      step("drop.d");
      step("drop.i1");
      step("drop.i2");
      chk("drop.noack1", 8'(ack1), 8'd0);

      // Random traffic with inputs changing every cycle
      for (int i = 0; i < 400; i++) begin
         req0 = ($urandom_range(0, 3) != 0);
         req1 = ($urandom_range(0, 2) != 0);
         oc0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
         oc1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         step("rnd");
         if ($urandom_range(0, 39) == 0) mid_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
